// File: rtl/cnn_layer_accel_weight_seq_pkg.sv
// rtl/cnn_layer_accel_weight_seq_pkg.sv - shared types and gray helpers for the weight sequencer
// Purpose: state enum, 2-bit gray code constants and the gray successor function
//          used by the weight sequence controller and sibling controllers.
// Ports:   none (package).
package cnn_layer_accel_weight_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;

  function automatic logic [1:0] gray_next(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      GRAY_0:  nxt = GRAY_1;
      GRAY_1:  nxt = GRAY_2;
      GRAY_2:  nxt = GRAY_3;
      default: nxt = GRAY_0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_cnt2.sv
// rtl/cnn_layer_accel_gray_cnt2.sv - 2-bit gray counter with sync reset, clear and enable
// Purpose: steps 00 -> 01 -> 11 -> 10 -> 00 on each enabled cycle.
// Ports:   clk, rst (sync, active-high), clr (sync clear to 00, wins over en),
//          en (advance one step), q (current gray value).
module cnn_layer_accel_gray_cnt2
  import cnn_layer_accel_weight_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= GRAY_0;
    end else if (en) begin
      q <= gray_next(q);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// rtl/cnn_layer_accel_weight_seq_ctrl.sv - weight sequence table lookup sequencer for one tile
// Purpose: walks C_SEQ_LEN slots per pixel over cfg_num_cols x cfg_num_rows pixels,
//          driving gray_code / sequence_selector / seq_data_addr to the weight
//          sequence table, with stall backpressure and a registered-output-aligned valid.
// Optional: WEIGHT_SEQ_CTRL_ABORT_EN adds the abort input (forces IDLE and pulses done).
// Ports:   clk, rst (sync, active-high); start, cfg_num_cols, cfg_num_rows (tile request);
//          stall (freeze); busy, done (status); gray_code, sequence_selector,
//          seq_data_addr, seq_valid (table lookup); wht_addr_valid (seq_valid delayed 1);
//          last_slot (final lookup of the tile).
module cnn_layer_accel_weight_seq_ctrl
  import cnn_layer_accel_weight_seq_pkg::*;
#(
  parameter int C_SEQ_LEN = 5,
  parameter int C_COL_W   = 10,
  parameter int C_ROW_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [C_COL_W-1:0] cfg_num_cols,
  input  logic [C_ROW_W-1:0] cfg_num_rows,
  input  logic               stall,
`ifdef WEIGHT_SEQ_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [1:0]         gray_code,
  output logic               sequence_selector,
  output logic [2:0]         seq_data_addr,
  output logic               seq_valid,
  output logic               wht_addr_valid,
  output logic               last_slot
);

  localparam logic [2:0]         LAST_ADDR = 3'(C_SEQ_LEN - 1);
  localparam logic [C_COL_W-1:0] COL_ONE   = 1;
  localparam logic [C_ROW_W-1:0] ROW_ONE   = 1;

  state_t             state;
  logic [C_COL_W-1:0] col;
  logic [C_ROW_W-1:0] row;
  logic [C_COL_W-1:0] cols_q;
  logic [C_ROW_W-1:0] rows_q;

  logic issue;
  logic slot_wrap;
  logic col_wrap;
  logic row_wrap;
  logic abort_hit;

  // A lookup is issued on every non-stalled RUN cycle; the counters below only move on issue.
  assign issue     = (state == RUN) && !stall;
  assign slot_wrap = (seq_data_addr == LAST_ADDR);
  assign col_wrap  = (col == cols_q - COL_ONE);
  assign row_wrap  = (row == rows_q - ROW_ONE);

  assign seq_valid = issue;
  assign last_slot = issue && slot_wrap && col_wrap && row_wrap;

`ifdef WEIGHT_SEQ_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Gray code steps once per completed row; it is cleared rather than stepped when the
  // tile ends so the table inputs return to their idle values.
  cnn_layer_accel_gray_cnt2 u_gray (
    .clk (clk),
    .rst (rst),
    .clr (last_slot || abort_hit),
    .en  (issue && slot_wrap && col_wrap),
    .q   (gray_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      sequence_selector <= 1'b1;
      seq_data_addr     <= 3'd0;
      col               <= '0;
      row               <= '0;
      cols_q            <= '0;
      rows_q            <= '0;
      wht_addr_valid    <= 1'b0;
    end else begin
      wht_addr_valid <= issue;
      done           <= 1'b0;
      if (abort_hit) begin
        state             <= IDLE;
        busy              <= 1'b0;
        done              <= 1'b1;
        sequence_selector <= 1'b1;
        seq_data_addr     <= 3'd0;
        col               <= '0;
        row               <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if ((cfg_num_cols != '0) && (cfg_num_rows != '0)) begin
                cols_q <= cfg_num_cols;
                rows_q <= cfg_num_rows;
                busy   <= 1'b1;
                state  <= RUN;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          RUN: begin
            if (issue) begin
              if (slot_wrap) begin
                seq_data_addr <= 3'd0;
                if (col_wrap) begin
                  col               <= '0;
                  sequence_selector <= 1'b1;
                  if (row_wrap) begin
                    row   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                  end else begin
                    row <= row + ROW_ONE;
                  end
                end else begin
                  col               <= col + COL_ONE;
                  sequence_selector <= ~sequence_selector;
                end
              end else begin
                seq_data_addr <= seq_data_addr + 3'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// tb/tb_cnn_layer_accel_weight_seq_ctrl.sv - self-checking bench for the weight sequencer
module tb_cnn_layer_accel_weight_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] cfg_num_cols;
  logic [9:0] cfg_num_rows;
  logic       stall;
`ifdef WEIGHT_SEQ_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic [1:0] gray_code;
  logic       sequence_selector;
  logic [2:0] seq_data_addr;
  logic       seq_valid;
  logic       wht_addr_valid;
  logic       last_slot;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    logic       s;
    logic [2:0] a;
    logic       l;
  } look_t;

  look_t exp_q[$];

  cnn_layer_accel_weight_seq_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_num_cols      (cfg_num_cols),
    .cfg_num_rows      (cfg_num_rows),
    .stall             (stall),
`ifdef WEIGHT_SEQ_CTRL_ABORT_EN
    .abort             (abort),
`endif
    .busy              (busy),
    .done              (done),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .seq_valid         (seq_valid),
    .wht_addr_valid    (wht_addr_valid),
    .last_slot         (last_slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] gray_of(input int r);
    logic [1:0] tab [4];
    tab[0] = 2'b00; tab[1] = 2'b01; tab[2] = 2'b11; tab[3] = 2'b10;
    return tab[r % 4];
  endfunction

  // Expected lookup list: row-major over pixels, C_SEQ_LEN slots each.
  task automatic build_model(input int cols, input int rows);
    look_t e;
    exp_q.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int s = 0; s < 5; s++) begin
          e.g = gray_of(r);
          e.s = (c % 2 == 0);
          e.a = 3'(s);
          e.l = (r == rows - 1) && (c == cols - 1) && (s == 4);
          exp_q.push_back(e);
        end
  endtask

  task automatic chk_idle_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, seq_valid, 0);
    chk({tag, "_gray"}, gray_code, 0);
    chk({tag, "_sel"}, sequence_selector, 1);
    chk({tag, "_addr"}, seq_data_addr, 0);
    chk({tag, "_last"}, last_slot, 0);
  endtask

  // mode: 0 no stall, 1 random stall, 2 directed stall, 3 start re-pulse + cfg change
  task automatic run_tile(input int cols, input int rows, input int mode,
                          input int stall_at, input int stall_len);
    int  cyc = 0;
    int  n_stall = 0;
    int  issued = 0;
    int  stalled_here = 0;
    logic prev_valid = 1'b0;
    bit  finished = 0;
    look_t f;
    build_model(cols, rows);
    @(negedge clk);
    cfg_num_cols = 10'(cols);
    cfg_num_rows = 10'(rows);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000 && !finished) begin
      stall = 1'b0;
      if (mode == 1) stall = ($urandom_range(0, 3) == 0);
      if (mode == 2 && issued == stall_at && stalled_here < stall_len) begin
        stall = 1'b1;
        stalled_here++;
      end
      if (mode == 3 && (cyc == 3 || cyc == 4)) begin
        start = (cyc == 3);
        cfg_num_cols = 10'($urandom_range(5, 9));
        cfg_num_rows = 10'($urandom_range(5, 9));
      end
      #1;
      chk("wav_lag", wht_addr_valid, prev_valid);
      if (exp_q.size() == 0) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", seq_valid, 0);
        chk("done_latency", cyc, issued + n_stall);
        finished = 1;
      end else begin
        f = exp_q[0];
        chk("run_done", done, 0);
        chk("run_busy", busy, 1);
        chk("valid", seq_valid, !stall);
        chk("gray", gray_code, f.g);
        chk("sel", sequence_selector, f.s);
        chk("addr", seq_data_addr, f.a);
        chk("last", last_slot, f.l && !stall);
        if (stall) n_stall++;
        if (seq_valid) begin
          void'(exp_q.pop_front());
          issued++;
        end
      end
      prev_valid = seq_valid;
      @(negedge clk);
      cyc++;
    end
    if (!finished) chk("tile_timeout", 0, 1);
    stall = 1'b0;
    start = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk_idle_vals("post");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    cfg_num_cols = '0;
    cfg_num_rows = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_wav", wht_addr_valid, 0);
    chk_idle_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    run_tile(2, 2, 0, 0, 0);
    run_tile(1, 5, 0, 0, 0);
    run_tile(3, 1, 2, 7, 3);

    // zero config: straight to DONE, never a lookup
    begin
      int dones = 0;
      int valids = 0;
      int busys = 0;
      @(negedge clk);
      cfg_num_cols = 10'd0;
      cfg_num_rows = 10'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (i == 0) chk("zero_done_first", done, 1);
        dones += int'(done);
        valids += int'(seq_valid) + int'(wht_addr_valid);
        busys += int'(busy);
        @(negedge clk);
      end
      chk("zero_done_count", dones, 1);
      chk("zero_valid_count", valids, 0);
      chk("zero_busy_count", busys, 0);
    end

    // reset mid-tile after 7 lookups
    begin
      int dones = 0;
      @(negedge clk);
      cfg_num_cols = 10'd4;
      cfg_num_rows = 10'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("pre_rst_addr", seq_data_addr, 1);
      chk("pre_rst_sel", sequence_selector, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_done", done, 0);
      chk("midrst_wav", wht_addr_valid, 0);
      chk_idle_vals("midrst");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        dones += int'(done) + int'(busy);
      end
      chk("midrst_quiet", dones, 0);
    end
    run_tile(1, 1, 0, 0, 0);

    run_tile(3, 3, 3, 0, 0);
    for (int t = 0; t < 4; t++)
      run_tile($urandom_range(1, 4), $urandom_range(1, 6), 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
